fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that funnels NUM_SRC AXI-Stream sources into one FIFO write port.
// A grant lasts until end of packet or MAX_BURST beats; every grant is decided from IDLE.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data,
    input  logic [NUM_SRC-1:0]            s_axis_valid,
    input  logic [NUM_SRC-1:0]            s_axis_last,
    output logic [NUM_SRC-1:0]            s_axis_ready,
    output logic [DATA_WIDTH-1:0]         m_axis_data,
    output logic                          m_axis_valid,
    output logic                          m_axis_last,
    input  logic                          m_axis_ready,
    input  logic                          full,
    output logic                          wr_en,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy
);
    localparam int                GID_W = $clog2(NUM_SRC);
    localparam int                CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]  CAP   = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            r_state, w_state_next;
    logic [GID_W-1:0]  r_grant_id, r_last_grant, w_next_grant;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [DATA_WIDTH-1:0] w_lane_data;
    logic              w_lane_valid, w_lane_last;
    logic              w_any_req, w_link_ok, w_transfer, w_release;

    assign w_any_req  = |s_axis_valid;
    assign w_link_ok  = m_axis_ready && !full;
    assign w_transfer = (r_state == GRANT) && w_lane_valid && w_link_ok;
    assign w_release  = w_transfer && (w_lane_last || r_beat_cnt == CAP);
    assign wr_en      = w_transfer;
    assign grant_id   = r_grant_id;

    // Walk offsets from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        logic [GID_W-1:0] w_idx;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_next_grant = '0;
        w_idx        = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_idx = GID_W'((int'(r_last_grant) + k) % NUM_SRC);
            if (s_axis_valid[w_idx]) w_next_grant = w_idx;
        end
    end

    always_comb begin
        w_lane_data  = '0;
        w_lane_valid = 1'b0;
        w_lane_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant_id == GID_W'(i)) begin
                w_lane_data  = s_axis_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_lane_valid = s_axis_valid[i];
                w_lane_last  = s_axis_last[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, with the async reset first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_next = GRANT;
            GRANT:   if (w_release) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        m_axis_data  = '0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        s_axis_ready = '0;
        busy         = 1'b0;
        if (r_state == GRANT) begin
            busy         = 1'b1;
            m_axis_data  = w_lane_data;
            m_axis_valid = w_lane_valid;
            m_axis_last  = w_lane_last;
            for (int i = 0; i < NUM_SRC; i++)
                s_axis_ready[i] = (r_grant_id == GID_W'(i)) && w_link_ok;
        end
    end

    // Grant bookkeeping: stalls leave everything untouched because no transfer happens.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant_id   <= '0;
            r_last_grant <= GID_W'(NUM_SRC - 1);
            r_beat_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (w_any_req) begin
                r_grant_id <= w_next_grant;
                r_beat_cnt <= '0;
            end
        end else if (w_transfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_release) r_last_grant <= r_grant_id;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-source beat queues feed the DUT, and an
// expected-beat scoreboard is checked on every wr_en together with the grant order.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int NS = 4;
    localparam int MB = 16;

    typedef struct packed {
        logic [1:0]    id;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NS*DW-1:0] s_axis_data = '0;
    logic [NS-1:0] s_axis_valid = '0;
    logic [NS-1:0] s_axis_last = '0;
    logic [NS-1:0] s_axis_ready;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid, m_axis_last, wr_en, busy;
    logic          m_axis_ready = 1'b1;
    logic          full = 1'b0;
    logic [1:0]    grant_id;

    beat_t src_q [NS][$];
    beat_t exp_q [$];
    int    grant_ids [$];
    int    grant_cyc [$];
    int    errors = 0;
    int    checks = 0;
    int    cycle = 0;
    int    wr_cnt = 0;
    int    t0;
    logic  prev_busy = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .full         (full),
        .wr_en        (wr_en),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int src, input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++)
            src_q[src].push_back('{id: 2'(src), last: (k == n - 1), data: base + DW'(k)});
    endtask

    task automatic expect_beats(input int src, input logic [DW-1:0] base, input int n,
                                input bit ends_packet);
        for (int k = 0; k < n; k++)
            exp_q.push_back('{id: 2'(src), last: ends_packet && (k == n - 1), data: base + DW'(k)});
    endtask

    function automatic bit pending();
        for (int i = 0; i < NS; i++)
            if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() != 0) begin
                s_axis_valid[i]          = 1'b1;
                s_axis_last[i]           = src_q[i][0].last;
                s_axis_data[i*DW +: DW]  = src_q[i][0].data;
            end else begin
                s_axis_valid[i]          = 1'b0;
                s_axis_last[i]           = 1'b0;
                s_axis_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    // One clock: present source heads just after the edge, sample mid-cycle, then pop
    // whatever the DUT accepted at the coming edge.
    task automatic step();
        beat_t e;
        drive();
        // NOTE: outputs are sampled mid-cycle, never on the active edge, to avoid races.
        #3;
        if (busy && !prev_busy) begin
            grant_ids.push_back(int'(grant_id));
            grant_cyc.push_back(cycle);
        end
        prev_busy = busy;
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(wr_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat", 32'({grant_id, m_axis_last, m_axis_data}), 32'(e));
            end
        end
        for (int i = 0; i < NS; i++)
            if (s_axis_valid[i] && s_axis_ready[i]) void'(src_q[i].pop_front());
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic run(input string tag, input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || pending()) && n < max_cycles) begin
            step();
            n++;
        end
        check(tag, 32'(n < max_cycles), 32'd1);
        drive();
    endtask

    task automatic run_beats(input string tag, input int beats, input int max_cycles);
        int n = 0;
        while (wr_cnt < beats && n < max_cycles) begin
            step();
            n++;
        end
        check(tag, 32'(wr_cnt), 32'(beats));
    endtask

    task automatic check_order(input string tag, input int n, input int ord [8]);
        check($sformatf("%s_count", tag), 32'(grant_ids.size()), 32'(n));
        for (int k = 0; k < n && k < grant_ids.size(); k++)
            check($sformatf("%s_%0d", tag, k), 32'(grant_ids[k]), 32'(ord[k]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(busy),         32'd0);
        check({tag, "_wr_en"},  32'(wr_en),        32'd0);
        check({tag, "_mvalid"}, 32'(m_axis_valid), 32'd0);
        check({tag, "_mlast"},  32'(m_axis_last),  32'd0);
        check({tag, "_sready"}, 32'(s_axis_ready), 32'd0);
    endtask

    task automatic clear_grant_log();
        grant_ids.delete();
        grant_cyc.delete();
    endtask

    initial begin
        // Reset with every source requesting: nothing may leak out.
        s_axis_valid = '1;
        s_axis_last  = '1;
        s_axis_data  = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_grant_id", 32'(grant_id), 32'd0);
        drive();
        reset = 1'b1;

        // Single source, 3-beat packet.
        load(2, 8'hA1, 3);
        expect_beats(2, 8'hA1, 3, 1'b1);
        t0 = cycle;
        run("single_budget", 20);
        check_order("single_grant", 1, '{2, 0, 0, 0, 0, 0, 0, 0});
        if (grant_cyc.size() > 0)
            check("single_latency", 32'(grant_cyc[0] - t0), 32'd1);
        check("single_busy_after", 32'(busy), 32'd0);
        check("single_wr_cnt", 32'(wr_cnt), 32'd3);

        // Fresh reset, then four sources with 1-beat packets (src0 has two).
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        prev_busy = 1'b0;
        clear_grant_log();
        load(0, 8'h30, 1);
        load(1, 8'h31, 1);
        load(2, 8'h32, 1);
        load(3, 8'h33, 1);
        load(0, 8'h34, 1);
        expect_beats(0, 8'h30, 1, 1'b1);
        expect_beats(1, 8'h31, 1, 1'b1);
        expect_beats(2, 8'h32, 1, 1'b1);
        expect_beats(3, 8'h33, 1, 1'b1);
        expect_beats(0, 8'h34, 1, 1'b1);
        run("rr_budget", 40);
        check_order("rr_order", 5, '{0, 1, 2, 3, 0, 0, 0, 0});
        for (int k = 1; k < grant_cyc.size(); k++)
            check($sformatf("rr_gap_%0d", k), 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd2);

        // Burst cap: 20-beat packet from src1 split 16 + 4 around src3's packet.
        clear_grant_log();
        load(1, 8'h10, 20);
        load(3, 8'hC0, 2);
        expect_beats(1, 8'h10, 16, 1'b0);
        expect_beats(3, 8'hC0, 2, 1'b1);
        expect_beats(1, 8'h20, 4, 1'b1);
        run("cap_budget", 80);
        check_order("cap_order", 3, '{1, 3, 1, 0, 0, 0, 0, 0});

        // Backpressure: full for 5 cycles after beat 2, then m_axis_ready low for 2.
        clear_grant_log();
        wr_cnt = 0;
        load(0, 8'h40, 4);
        expect_beats(0, 8'h40, 4, 1'b1);
        run_beats("bp_first_two", 2, 20);
        full = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) begin
                full = 1'b0;
                m_axis_ready = 1'b0;
            end
            drive();
            #3;
            check($sformatf("stall_wr_en_%0d", k),  32'(wr_en),        32'd0);
            check($sformatf("stall_sready_%0d", k), 32'(s_axis_ready), 32'd0);
            check($sformatf("stall_hold_%0d", k),
                  32'({busy, grant_id, m_axis_valid, m_axis_data}), 32'({1'b1, 2'd0, 1'b1, 8'h42}));
            @(posedge clk);
            #1;
            cycle++;
        end
        m_axis_ready = 1'b1;
        run("bp_budget", 20);
        check("bp_wr_cnt", 32'(wr_cnt), 32'd4);

        // Mid-burst reset: src1 aborted after beat 2, src0 must win first afterwards.
        wr_cnt = 0;
        load(1, 8'h50, 4);
        load(0, 8'h5A, 1);
        expect_beats(1, 8'h50, 2, 1'b0);
        run_beats("mid_first_two", 2, 20);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        src_q[1].delete();
        exp_q.delete();
        load(3, 8'h6A, 1);
        expect_beats(0, 8'h5A, 1, 1'b1);
        expect_beats(3, 8'h6A, 1, 1'b1);
        drive();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            cycle++;
            check($sformatf("mid_hold_wr_en_%0d", k), 32'(wr_en), 32'd0);
            check($sformatf("mid_hold_busy_%0d", k),  32'(busy),  32'd0);
        end
        reset = 1'b1;
        prev_busy = 1'b0;
        clear_grant_log();
        run("post_reset_budget", 20);
        check_order("post_reset_order", 2, '{0, 3, 0, 0, 0, 0, 0, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
